// File: rtl/id_stage.sv
// id_stage: registered RV32I decode with EX/MEM forwarding,
// load-use stall and a valid/ready handshake toward EX.
module id_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  // b30 + funct3 + opcode[6:0] = 11 bits
  parameter int OPC_W  = 11,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [31:0]       inst_i,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  input  logic [XLEN-1:0]   reg1_data_i,
  input  logic [XLEN-1:0]   reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic              ex_load_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [XLEN-1:0]   ex_wdata_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OPC_W-1:0]  opcode_o,
  output logic [XLEN-1:0]   reg1_o,
  output logic [XLEN-1:0]   reg2_o,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic              illegal_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [XLEN-1:0]   reg1;
    logic [XLEN-1:0]   reg2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic              illegal;
  } id_ex_t;

  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0]   fwd1, fwd2;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign rs1 = inst_i[19:15];
  assign rs2 = inst_i[24:20];
  assign rd  = inst_i[11:7];

  assign imm_i = {{21{inst_i[31]}}, inst_i[30:20]};
  assign imm_s = {{21{inst_i[31]}}, inst_i[30:25], inst_i[11:7]};
  assign imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25],
                  inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20],
                  inst_i[30:21], 1'b0};

  assign reg1_addr_o = rs1;
  assign reg2_addr_o = rs2;

  // operand source: x0, then EX (non-load), then MEM, then regfile
  always_comb begin
    fwd1 = reg1_data_i;
    fwd2 = reg2_data_i;
    if (FWD_EN && mem_wreg_i && mem_wd_i == rs1) fwd1 = mem_wdata_i;
    if (FWD_EN && mem_wreg_i && mem_wd_i == rs2) fwd2 = mem_wdata_i;
    if (FWD_EN && ex_wreg_i && !ex_load_i && ex_wd_i == rs1)
      fwd1 = ex_wdata_i;
    if (FWD_EN && ex_wreg_i && !ex_load_i && ex_wd_i == rs2)
      fwd2 = ex_wdata_i;
    if (rs1 == '0) fwd1 = '0;
    if (rs2 == '0) fwd2 = '0;
  end

  id_ex_t dec;
  logic   b30;
  logic [2:0] f3_o;

  // format decode: reads, operands, immediate, write enable
  always_comb begin
    dec         = '0;
    reg1_read_o = 1'b0;
    reg2_read_o = 1'b0;
    b30         = 1'b0;
    f3_o        = f3;
    unique case (1'b1)
      opc == OP_R: begin
        reg1_read_o = 1'b1;
        reg2_read_o = 1'b1;
        b30         = inst_i[30];
        dec.reg1    = fwd1;
        dec.reg2    = fwd2;
        dec.wreg    = 1'b1;
      end
      opc == OP_IALU: begin
        reg1_read_o = 1'b1;
        b30         = (f3 == 3'b101) && inst_i[30];
        dec.imm     = imm_i;
        dec.reg1    = fwd1;
        dec.reg2    = imm_i;
        dec.wreg    = 1'b1;
      end
      opc == OP_LOAD: begin
        reg1_read_o = 1'b1;
        dec.imm     = imm_i;
        dec.reg1    = fwd1;
        dec.reg2    = imm_i;
        dec.wreg    = 1'b1;
      end
      opc == OP_STORE: begin
        reg1_read_o = 1'b1;
        reg2_read_o = 1'b1;
        dec.imm     = imm_s;
        dec.reg1    = fwd1;
        dec.reg2    = imm_s;
      end
      opc == OP_BR: begin
        reg1_read_o = 1'b1;
        reg2_read_o = 1'b1;
        dec.imm     = imm_b;
        dec.reg1    = fwd1;
        dec.reg2    = fwd2;
      end
      opc == OP_LUI: begin
        f3_o     = 3'b0;
        dec.imm  = imm_u;
        dec.reg2 = imm_u;
        dec.wreg = 1'b1;
      end
      opc == OP_AUIPC: begin
        f3_o     = 3'b0;
        dec.imm  = imm_u;
        dec.reg1 = pc_i;
        dec.reg2 = imm_u;
        dec.wreg = 1'b1;
      end
      opc == OP_JAL: begin
        f3_o     = 3'b0;
        dec.imm  = imm_j;
        dec.reg1 = pc_i;
        dec.reg2 = XLEN'(4);
        dec.wreg = 1'b1;
      end
      opc == OP_JALR: begin
        reg1_read_o = 1'b1;
        dec.imm     = imm_i;
        dec.reg1    = pc_i;
        dec.reg2    = XLEN'(4);
        dec.wreg    = 1'b1;
      end
      opc == OP_FENCE,
      opc == OP_SYS: begin
        dec.imm = imm_i;
      end
      default: begin
        dec.illegal = 1'b1;
        f3_o        = 3'b0;
      end
    endcase
    if (!dec.illegal) dec.opcode = {b30, f3_o, opc};
    if (rd == '0) dec.wreg = 1'b0;
    dec.rs1_data = reg1_read_o ? fwd1 : '0;
    dec.rs2_data = reg2_read_o ? fwd2 : '0;
    dec.pc       = pc_i;
    dec.wd       = rd;
  end

  logic   valid_q, valid_d;
  id_ex_t ex_q, ex_d;
  logic   adv, haz;

  assign adv = !valid_q || out_ready_i;
  assign haz = in_valid_i && ex_load_i && ex_wreg_i && ex_wd_i != '0 &&
               ((reg1_read_o && rs1 == ex_wd_i) ||
                (reg2_read_o && rs2 == ex_wd_i));
  assign in_ready_o = flush_i || (adv && !haz);

  // pipeline register update: flush > bubble > load > drain > hold
  always_comb begin
    valid_d = valid_q;
    ex_d    = ex_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (adv && haz) begin
      valid_d = 1'b0;
      ex_d.wreg = 1'b0;
    end else if (adv && in_valid_i) begin
      valid_d = 1'b1;
      ex_d    = dec;
    end else if (adv) begin
      valid_d = 1'b0;
    end
  end

  // ID/EX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ex_q    <= ex_d;
    end
  end

  assign out_valid_o = valid_q;
  assign opcode_o    = ex_q.opcode;
  assign reg1_o      = ex_q.reg1;
  assign reg2_o      = ex_q.reg2;
  assign rs1_data_o  = ex_q.rs1_data;
  assign rs2_data_o  = ex_q.rs2_data;
  assign imm_o       = ex_q.imm;
  assign pc_o        = ex_q.pc;
  assign wd_o        = ex_q.wd;
  assign wreg_o      = ex_q.wreg;
  assign illegal_o   = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors for id_stage with
// hand-computed expectations.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o;
  logic [31:0] pc_i, inst_i;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic        reg1_read_o, reg2_read_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_load_i;
  logic [4:0]  ex_wd_i;
  logic [31:0] ex_wdata_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic        flush_i, out_valid_o, out_ready_i;
  logic [10:0] opcode_o;
  logic [31:0] reg1_o, reg2_o, rs1_data_o, rs2_data_o;
  logic [31:0] imm_o, pc_o;
  logic [4:0]  wd_o;
  logic        wreg_o, illegal_o;

  int n_vec = 0;
  int n_bad = 0;

  id_stage dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_load_i(ex_load_i),
    .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
    .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .opcode_o(opcode_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .pc_o(pc_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    in_valid_i = 1'b1;
    pc_i = 32'h100;
    inst_i = 32'h00500093;
    reg1_data_i = 32'h11;
    reg2_data_i = 32'h22;
    ex_wreg_i = 1'b1;
    ex_load_i = 1'b0;
    ex_wd_i = 5'd0;
    ex_wdata_i = 32'h77;
    mem_wreg_i = 1'b0;
    mem_wd_i = 5'd0;
    mem_wdata_i = 32'h0;
    flush_i = 1'b0;
    out_ready_i = 1'b1;

    repeat (3) tick();
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_opc", 32'(opcode_o), 32'd0);
    chk("rst_reg1", reg1_o, 32'd0);
    chk("rst_reg2", reg2_o, 32'd0);
    chk("rst_imm", imm_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_ill", 32'(illegal_o), 32'd0);
    rst = 1'b1;

    tick();
    chk("addi_valid", 32'(out_valid_o), 32'd1);
    chk("addi_opc", 32'(opcode_o), 32'h013);
    chk("addi_reg1", reg1_o, 32'd0);
    chk("addi_reg2", reg2_o, 32'd5);
    chk("addi_imm", imm_o, 32'd5);
    chk("addi_rs1d", rs1_data_o, 32'd0);
    chk("addi_wd", 32'(wd_o), 32'd1);
    chk("addi_wreg", 32'(wreg_o), 32'd1);
    chk("addi_pc", pc_o, 32'h100);

    inst_i = 32'h123452B7;
    pc_i = 32'h104;
    tick();
    chk("lui_opc", 32'(opcode_o), 32'h037);
    chk("lui_reg1", reg1_o, 32'd0);
    chk("lui_reg2", reg2_o, 32'h12345000);
    chk("lui_wd", 32'(wd_o), 32'd5);
    chk("lui_wreg", 32'(wreg_o), 32'd1);

    inst_i = 32'h002081B3;
    ex_wd_i = 5'd1;
    ex_wdata_i = 32'd7;
    mem_wreg_i = 1'b1;
    mem_wd_i = 5'd2;
    mem_wdata_i = 32'd9;
    #1;
    chk("add_rdy", 32'(in_ready_o), 32'd1);
    chk("add_r1rd", 32'(reg1_read_o), 32'd1);
    chk("add_r2addr", 32'(reg2_addr_o), 32'd2);
    tick();
    chk("fwd_opc", 32'(opcode_o), 32'h033);
    chk("fwd_reg1", reg1_o, 32'd7);
    chk("fwd_reg2", reg2_o, 32'd9);
    chk("fwd_rs2d", rs2_data_o, 32'd9);
    chk("fwd_wd", 32'(wd_o), 32'd3);

    mem_wd_i = 5'd1;
    tick();
    chk("prio_reg1", reg1_o, 32'd7);
    chk("prio_reg2", reg2_o, 32'h22);

    ex_wreg_i = 1'b0;
    tick();
    chk("memfwd_reg1", reg1_o, 32'd9);

    mem_wreg_i = 1'b0;
    ex_wreg_i = 1'b1;
    ex_load_i = 1'b1;
    #1;
    chk("lu_rdy", 32'(in_ready_o), 32'd0);
    tick();
    chk("lu_valid", 32'(out_valid_o), 32'd0);
    chk("lu_wreg", 32'(wreg_o), 32'd0);
    ex_load_i = 1'b0;
    ex_wreg_i = 1'b0;
    #1;
    chk("lu_rdy2", 32'(in_ready_o), 32'd1);
    tick();
    chk("lu_valid2", 32'(out_valid_o), 32'd1);
    chk("lu_reg1", reg1_o, 32'h11);
    chk("lu_reg2", reg2_o, 32'h22);
    chk("lu_wreg2", 32'(wreg_o), 32'd1);

    out_ready_i = 1'b0;
    inst_i = 32'h123452B7;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_rdy", 32'(in_ready_o), 32'd0);
      tick();
      chk("bp_valid", 32'(out_valid_o), 32'd1);
      chk("bp_opc", 32'(opcode_o), 32'h033);
      chk("bp_reg1", reg1_o, 32'h11);
    end
    flush_i = 1'b1;
    #1;
    chk("fl_rdy", 32'(in_ready_o), 32'd1);
    tick();
    chk("fl_valid", 32'(out_valid_o), 32'd0);
    flush_i = 1'b0;
    out_ready_i = 1'b1;

    inst_i = 32'hFFFFFFFF;
    #1;
    chk("ill_r1rd", 32'(reg1_read_o), 32'd0);
    tick();
    chk("ill_valid", 32'(out_valid_o), 32'd1);
    chk("ill_flag", 32'(illegal_o), 32'd1);
    chk("ill_wreg", 32'(wreg_o), 32'd0);
    chk("ill_opc", 32'(opcode_o), 32'd0);
    chk("ill_reg1", reg1_o, 32'd0);
    chk("ill_reg2", reg2_o, 32'd0);

    inst_i = 32'h00100013;
    tick();
    chk("x0_wreg", 32'(wreg_o), 32'd0);
    chk("x0_ill", 32'(illegal_o), 32'd0);
    chk("x0_reg2", reg2_o, 32'd1);

    inst_i = 32'h0020A423;
    tick();
    chk("sw_opc", 32'(opcode_o), 32'h123);
    chk("sw_imm", imm_o, 32'd8);
    chk("sw_reg2", reg2_o, 32'd8);
    chk("sw_rs2d", rs2_data_o, 32'h22);
    chk("sw_wreg", 32'(wreg_o), 32'd0);

    inst_i = 32'hFE208EE3;
    tick();
    chk("beq_opc", 32'(opcode_o), 32'h063);
    chk("beq_imm", imm_o, 32'hFFFFFFFC);
    chk("beq_reg1", reg1_o, 32'h11);
    chk("beq_reg2", reg2_o, 32'h22);

    inst_i = 32'h008000EF;
    pc_i = 32'h200;
    tick();
    chk("jal_opc", 32'(opcode_o), 32'h06F);
    chk("jal_reg1", reg1_o, 32'h200);
    chk("jal_reg2", reg2_o, 32'd4);
    chk("jal_imm", imm_o, 32'd8);
    chk("jal_wreg", 32'(wreg_o), 32'd1);

    inst_i = 32'h4030D093;
    tick();
    chk("srai_opc", 32'(opcode_o), 32'h693);

    in_valid_i = 1'b0;
    tick();
    chk("idle_valid", 32'(out_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
